// File: rtl/icache_pkg.sv
// Shared widths and state encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int MEM_ADD_W      = 32;
    localparam int INS_DAT_W      = 32;
    localparam int ICACHE_INDEX_W = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, between fetch and the memory controller.
// Hits answer one cycle after lookup; misses issue a single request pulse and forward the returned word.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iIF_En,
    input  logic [MEM_ADD_W-1:0] iIF_Pc,
    input  logic                 iIF_Flush,
    output logic                 oIF_En,
    output logic [INS_DAT_W-1:0] oIF_Ins,
    output logic                 oIF_Busy,
    output logic                 oMC_En,
    output logic [MEM_ADD_W-1:0] oMC_Pc,
    input  logic                 iMC_En,
    input  logic [INS_DAT_W-1:0] iMC_Ins
);

    localparam int TAG_W  = MEM_ADD_W - INDEX_W - 2;
    localparam int WORD_W = MEM_ADD_W - 2;
    localparam int LINES  = 1 << INDEX_W;

    state_t                 state_q;
    logic [LINES-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [INS_DAT_W-1:0]   data_mem [LINES];

    logic                   pend_q;
    logic [WORD_W-1:0]      pend_word_q;
    logic                   discard_q;
    logic [INDEX_W-1:0]     wait_index_q;
    logic [TAG_W-1:0]       wait_tag_q;

    logic                   if_en_q;
    logic [INS_DAT_W-1:0]   if_ins_q;
    logic                   mc_en_q;
    logic [MEM_ADD_W-1:0]   mc_pc_q;

    logic                   req_valid;
    logic [WORD_W-1:0]      req_word;
    logic [INDEX_W-1:0]     req_index;
    logic [TAG_W-1:0]       req_tag;
    logic                   hit;
    logic                   fill;
    logic                   unused_pc_bits;

    assign unused_pc_bits = ^iIF_Pc[1:0];

    // A fresh request beats the pending one; a bare flush cancels the pending lookup.
    always_comb begin
        req_valid = 1'b0;
        req_word  = pend_word_q;
        if (state_q == S_IDLE) begin
            if (iIF_En) begin
                req_valid = 1'b1;
                req_word  = iIF_Pc[MEM_ADD_W-1:2];
            end else if (pend_q && !iIF_Flush) begin
                req_valid = 1'b1;
            end
        end
        req_index = req_word[INDEX_W-1:0];
        req_tag   = req_word[WORD_W-1:INDEX_W];
        hit       = valid_q[req_index] && (tag_mem[req_index] == req_tag);
        fill      = (state_q == S_WAIT) && iMC_En;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            pend_q       <= 1'b0;
            pend_word_q  <= '0;
            discard_q    <= 1'b0;
            wait_index_q <= '0;
            wait_tag_q   <= '0;
            if_en_q      <= 1'b0;
            if_ins_q     <= '0;
            mc_en_q      <= 1'b0;
            mc_pc_q      <= '0;
        end else if (en) begin
            if_en_q <= 1'b0;
            mc_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    pend_q <= 1'b0;
                    if (req_valid && hit) begin
                        if_en_q  <= 1'b1;
                        if_ins_q <= data_mem[req_index];
                    end else if (req_valid) begin
                        mc_en_q      <= 1'b1;
                        mc_pc_q      <= {req_word, 2'b00};
                        wait_index_q <= req_index;
                        wait_tag_q   <= req_tag;
                        discard_q    <= 1'b0;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (iIF_En) begin
                        pend_q      <= 1'b1;
                        pend_word_q <= iIF_Pc[MEM_ADD_W-1:2];
                    end else if (iIF_Flush) begin
                        pend_q <= 1'b0;
                    end
                    // The controller cannot abort, so a flushed fill still lands in the arrays.
                    if (iMC_En) begin
                        valid_q[wait_index_q] <= 1'b1;
                        if (!(discard_q || iIF_Flush)) begin
                            if_en_q  <= 1'b1;
                            if_ins_q <= iMC_Ins;
                        end
                        discard_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (iIF_Flush) begin
                        discard_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && en && fill) begin
            tag_mem[wait_index_q]  <= wait_tag_q;
            data_mem[wait_index_q] <= iMC_Ins;
        end
    end

    assign oIF_En   = if_en_q;
    assign oIF_Ins  = if_ins_q;
    assign oIF_Busy = (state_q == S_WAIT) || pend_q;
    assign oMC_En   = mc_en_q;
    assign oMC_Pc   = mc_pc_q;

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus random fetches against a line-level direct-mapped model.
module tb_icache;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        iIF_En;
    logic [31:0] iIF_Pc;
    logic        iIF_Flush;
    logic        oIF_En;
    logic [31:0] oIF_Ins;
    logic        oIF_Busy;
    logic        oMC_En;
    logic [31:0] oMC_Pc;
    logic        iMC_En;
    logic [31:0] iMC_Ins;

    int total = 0;
    int bad   = 0;

    // model: 256 lines, each remembers which word address it holds and its data
    bit          line_valid [256];
    logic [31:0] line_addr  [256];
    logic [31:0] line_data  [256];
    logic [31:0] mem_model  [logic [31:0]];
    logic [31:0] last_ins;
    logic [31:0] exp_q[$];

    icache dut (
        .clk(clk), .rst(rst), .en(en),
        .iIF_En(iIF_En), .iIF_Pc(iIF_Pc), .iIF_Flush(iIF_Flush),
        .oIF_En(oIF_En), .oIF_Ins(oIF_Ins), .oIF_Busy(oIF_Busy),
        .oMC_En(oMC_En), .oMC_Pc(oMC_Pc),
        .iMC_En(iMC_En), .iMC_Ins(iMC_Ins)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        logic [31:0] a;
        a = {pc[31:2], 2'b00};
        if (!mem_model.exists(a)) mem_model[a] = $urandom;
        return mem_model[a];
    endfunction

    function automatic int line_of(input logic [31:0] pc);
        return int'((pc >> 2) % 256);
    endfunction

    task automatic model_fill(input logic [31:0] pc);
        line_valid[line_of(pc)] = 1'b1;
        line_addr[line_of(pc)]  = pc >> 2;
        line_data[line_of(pc)]  = mem_word(pc);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) line_valid[i] = 1'b0;
        last_ins = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; iIF_En = 1'b0; iIF_Flush = 1'b0; iMC_En = 1'b0;
        iIF_Pc = '0; iMC_Ins = '0;
        repeat (2) step();
        rst = 1'b0;
        model_clear();
    endtask

    // Complete fetch: either a one-cycle hit or a miss served after lat idle cycles.
    task automatic run_fetch(input logic [31:0] pc, input int lat);
        bit          exp_hit;
        logic [31:0] exp;
        exp_hit = line_valid[line_of(pc)] && (line_addr[line_of(pc)] == (pc >> 2));
        iIF_En = 1'b1; iIF_Pc = pc;
        step();
        iIF_En = 1'b0;
        if (!exp_hit) begin
            total++;
            if (oMC_En !== 1'b1 || oMC_Pc !== {pc[31:2], 2'b00} || oIF_En !== 1'b0 || oIF_Busy !== 1'b1) begin
                bad++;
                $display("FAIL miss_req pc=%h: mc_en=%b mc_pc=%h if_en=%b busy=%b, want 1 %h 0 1",
                         pc, oMC_En, oMC_Pc, oIF_En, oIF_Busy, {pc[31:2], 2'b00});
            end
            for (int i = 0; i < lat; i++) begin
                step();
                total++;
                if (oMC_En !== 1'b0 || oIF_En !== 1'b0) begin
                    bad++;
                    $display("FAIL miss_wait pc=%h cyc=%0d: mc_en=%b if_en=%b, want 0 0", pc, i, oMC_En, oIF_En);
                end
            end
            iMC_En = 1'b1; iMC_Ins = mem_word(pc);
            step();
            iMC_En = 1'b0; iMC_Ins = $urandom;
            model_fill(pc);
        end
        exp_q.push_back(line_data[line_of(pc)]);
        exp = exp_q.pop_front();
        last_ins = exp;
        total++;
        if (oIF_En !== 1'b1 || oIF_Ins !== exp || oMC_En !== 1'b0) begin
            bad++;
            $display("FAIL fetch_resp pc=%h hit=%0d: if_en=%b ins=%h mc_en=%b, want 1 %h 0",
                     pc, exp_hit, oIF_En, oIF_Ins, oMC_En, exp);
        end
        step();
        total++;
        if (oIF_En !== 1'b0 || oMC_En !== 1'b0 || oIF_Busy !== 1'b0) begin
            bad++;
            $display("FAIL fetch_after pc=%h: if_en=%b mc_en=%b busy=%b, want 0 0 0", pc, oIF_En, oMC_En, oIF_Busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        mem_model[32'h100] = 32'h00A00093;
        mem_model[32'h500] = 32'h12345678;
        total++;
        if (oIF_En !== 1'b0 || oMC_En !== 1'b0 || oIF_Busy !== 1'b0 || oIF_Ins !== 32'h0 || oMC_Pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_outs: if_en=%b mc_en=%b busy=%b ins=%h mc_pc=%h, want all 0",
                     oIF_En, oMC_En, oIF_Busy, oIF_Ins, oMC_Pc);
        end
    endtask

    task automatic test_miss_hit();
        run_fetch(32'h100, 2);
        run_fetch(32'h100, 0);
    endtask

    task automatic test_conflict();
        run_fetch(32'h500, 1);
        run_fetch(32'h100, 3);
    endtask

    task automatic test_flush_wait();
        iIF_En = 1'b1; iIF_Pc = 32'h200;
        step();
        iIF_En = 1'b0;
        total++;
        if (oMC_En !== 1'b1 || oMC_Pc !== 32'h200) begin
            bad++;
            $display("FAIL flushw_req: mc_en=%b mc_pc=%h, want 1 00000200", oMC_En, oMC_Pc);
        end
        step();
        iIF_Flush = 1'b1; iIF_En = 1'b1; iIF_Pc = 32'h300;
        step();
        iIF_Flush = 1'b0; iIF_En = 1'b0;
        step();
        iMC_En = 1'b1; iMC_Ins = mem_word(32'h200);
        step();
        iMC_En = 1'b0;
        model_fill(32'h200);
        total++;
        if (oIF_En !== 1'b0 || oIF_Ins !== last_ins) begin
            bad++;
            $display("FAIL flushw_discard: if_en=%b ins=%h, want 0 %h", oIF_En, oIF_Ins, last_ins);
        end
        step();
        total++;
        if (oMC_En !== 1'b1 || oMC_Pc !== 32'h300) begin
            bad++;
            $display("FAIL flushw_pending: mc_en=%b mc_pc=%h, want 1 00000300", oMC_En, oMC_Pc);
        end
        step();
        iMC_En = 1'b1; iMC_Ins = mem_word(32'h300);
        step();
        iMC_En = 1'b0;
        model_fill(32'h300);
        last_ins = mem_word(32'h300);
        total++;
        if (oIF_En !== 1'b1 || oIF_Ins !== last_ins) begin
            bad++;
            $display("FAIL flushw_fill: if_en=%b ins=%h, want 1 %h", oIF_En, oIF_Ins, last_ins);
        end
        step();
        run_fetch(32'h200, 0);
    endtask

    task automatic test_pending_overwrite();
        do_reset();
        iIF_En = 1'b1; iIF_Pc = 32'h203;
        step();
        total++;
        if (oMC_En !== 1'b1 || oMC_Pc !== 32'h200) begin
            bad++;
            $display("FAIL align_pc: mc_en=%b mc_pc=%h, want 1 00000200", oMC_En, oMC_Pc);
        end
        iIF_Pc = 32'h600;
        step();
        iIF_Pc = 32'h700;
        step();
        iIF_En = 1'b0;
        total++;
        if (oMC_En !== 1'b0 || oIF_Busy !== 1'b1) begin
            bad++;
            $display("FAIL pend_wait: mc_en=%b busy=%b, want 0 1", oMC_En, oIF_Busy);
        end
        iMC_En = 1'b1; iMC_Ins = mem_word(32'h200);
        step();
        iMC_En = 1'b0;
        model_fill(32'h200);
        total++;
        if (oIF_En !== 1'b1 || oIF_Ins !== mem_word(32'h200)) begin
            bad++;
            $display("FAIL pend_fill1: if_en=%b ins=%h, want 1 %h", oIF_En, oIF_Ins, mem_word(32'h200));
        end
        step();
        total++;
        if (oMC_En !== 1'b1 || oMC_Pc !== 32'h700) begin
            bad++;
            $display("FAIL pend_last: mc_en=%b mc_pc=%h, want 1 00000700", oMC_En, oMC_Pc);
        end
        iMC_En = 1'b1; iMC_Ins = mem_word(32'h700);
        step();
        iMC_En = 1'b0;
        model_fill(32'h700);
        last_ins = mem_word(32'h700);
        total++;
        if (oIF_En !== 1'b1 || oIF_Ins !== last_ins) begin
            bad++;
            $display("FAIL pend_fill2: if_en=%b ins=%h, want 1 %h", oIF_En, oIF_Ins, last_ins);
        end
        step();
        step();
        total++;
        if (oMC_En !== 1'b0 || oIF_En !== 1'b0 || oIF_Busy !== 1'b0) begin
            bad++;
            $display("FAIL pend_done: mc_en=%b if_en=%b busy=%b, want 0 0 0", oMC_En, oIF_En, oIF_Busy);
        end
    endtask

    task automatic test_flush_idle();
        iIF_En = 1'b1; iIF_Pc = 32'hA00;
        step();
        iIF_Pc = 32'h104;
        step();
        iIF_En = 1'b0;
        iMC_En = 1'b1; iMC_Ins = mem_word(32'hA00);
        step();
        iMC_En = 1'b0;
        model_fill(32'hA00);
        last_ins = mem_word(32'hA00);
        total++;
        if (oIF_En !== 1'b1 || oIF_Ins !== last_ins || oIF_Busy !== 1'b1) begin
            bad++;
            $display("FAIL flushi_fill: if_en=%b ins=%h busy=%b, want 1 %h 1", oIF_En, oIF_Ins, oIF_Busy, last_ins);
        end
        iIF_Flush = 1'b1;
        step();
        iIF_Flush = 1'b0;
        step();
        total++;
        if (oMC_En !== 1'b0 || oIF_En !== 1'b0 || oIF_Busy !== 1'b0) begin
            bad++;
            $display("FAIL flushi_cancel: mc_en=%b if_en=%b busy=%b, want 0 0 0", oMC_En, oIF_En, oIF_Busy);
        end
    endtask

    task automatic test_reset_wait_and_en();
        run_fetch(32'h100, 1);
        iIF_En = 1'b1; iIF_Pc = 32'h400;
        step();
        iIF_En = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        iMC_En = 1'b1; iMC_Ins = 32'hDEADBEEF;
        step();
        iMC_En = 1'b0;
        step();
        total++;
        if (oIF_En !== 1'b0 || oIF_Busy !== 1'b0 || oIF_Ins !== 32'h0) begin
            bad++;
            $display("FAIL rst_stray: if_en=%b busy=%b ins=%h, want 0 0 0", oIF_En, oIF_Busy, oIF_Ins);
        end
        run_fetch(32'h100, 2);
        en = 1'b0; iIF_En = 1'b1; iIF_Pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (oIF_En !== 1'b0) begin
                bad++;
                $display("FAIL en_hold cyc=%0d: if_en=%b, want 0", i, oIF_En);
            end
        end
        en = 1'b1;
        step();
        iIF_En = 1'b0;
        total++;
        if (oIF_En !== 1'b1 || oIF_Ins !== 32'h00A00093) begin
            bad++;
            $display("FAIL en_hit: if_en=%b ins=%h, want 1 00a00093", oIF_En, oIF_Ins);
        end
        en = 1'b0;
        repeat (2) step();
        total++;
        if (oIF_En !== 1'b1) begin
            bad++;
            $display("FAIL en_freeze: if_en=%b, want 1", oIF_En);
        end
        en = 1'b1;
        step();
        total++;
        if (oIF_En !== 1'b0) begin
            bad++;
            $display("FAIL en_release: if_en=%b, want 0", oIF_En);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        pool[0] = 32'h100; pool[1] = 32'h500; pool[2] = 32'h900; pool[3] = 32'h104;
        pool[4] = 32'h3FC; pool[5] = 32'h7FC; pool[6] = 32'hFFFF_FF00; pool[7] = 32'h202;
        for (int n = 0; n < 60; n++) begin
            run_fetch(pool[$urandom_range(0, 7)], int'($urandom_range(0, 4)));
        end
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_conflict();
        test_flush_wait();
        test_pending_overwrite();
        test_flush_idle();
        test_reset_wait_and_en();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
